// File: rtl/apb_master_bridge_if.sv
// Command/response and APB3 bus bundle for apb_master_bridge.
// The master modport is the bridge view; slave is the controller-plus-peripheral view.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 requester, one transfer at a time (SETUP, ACCESS with waits, RESP).
// Optional ACCESS timeout abort when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_t;

    state_t            state;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    assign bus.cmd_ready = (state == IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q  <= bus.cmd_addr;
                        pwrite_q <= bus.cmd_write;
                        pwdata_q <= bus.cmd_wdata;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                        rsp_err_q   <= bus.PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // Abort on the edge that would bring the wait count to TIMEOUT_CYCLES.
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
